// File: rtl/contadores_pkg.sv
// Shared types and default sizes for the counter RAM and its read-side sequencer.
package contadores_pkg;

    localparam int unsigned BITS_DIRECT  = 6;
    localparam int unsigned SIZE_COUNTER = 4;

    // Scan sequencer states; the NEXT decision is folded into SEND/CLEAR/WAIT.
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StSend,
        StClear,
        StDone
    } state_e;

endpackage

// File: rtl/contadores_if.sv
// Counter RAM read/clear port plus the {address, count} valid/ready output stream.
interface contadores_if
    import contadores_pkg::*;
#(
    parameter int unsigned bitsDirect  = BITS_DIRECT,
    parameter int unsigned sizeCounter = SIZE_COUNTER
) ();

    logic [bitsDirect-1:0]  ram_adress;
    logic                   ram_count_read;
    logic                   ram_count_reset;
    logic [sizeCounter-1:0] ram_count_out;

    logic                   out_valid;
    logic                   out_ready;
    logic [bitsDirect-1:0]  out_addr;
    logic [sizeCounter-1:0] out_count;

    modport master (
        output ram_adress,
        output ram_count_read,
        output ram_count_reset,
        input  ram_count_out,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_count
    );

    modport slave (
        input  ram_adress,
        input  ram_count_read,
        input  ram_count_reset,
        output ram_count_out,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_count
    );

endinterface

// File: rtl/contadores_addr_gen.sv
// Scan index register: loads the range at start, steps modulo 2**bitsDirect, flags the last entry.
module contadores_addr_gen
    import contadores_pkg::*;
#(
    parameter int unsigned bitsDirect = BITS_DIRECT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [bitsDirect-1:0] first_addr_i,
    input  logic [bitsDirect-1:0] last_addr_i,
    output logic [bitsDirect-1:0] idx_o,
    output logic [bitsDirect-1:0] idx_inc_o,
    output logic                  is_last_o
);

    logic [bitsDirect-1:0] idx_q;
    logic [bitsDirect-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            last_q <= '0;
        end else if (load_i) begin
            idx_q  <= first_addr_i;
            last_q <= last_addr_i;
        end else if (inc_i) begin
            idx_q  <= idx_inc_o;
        end
    end

    // Natural overflow gives the wrap through the top address back to 0.
    assign idx_inc_o = idx_q + 1'b1;
    assign idx_o     = idx_q;
    assign is_last_o = (idx_q == last_q);

endmodule

// File: rtl/contadores_reader.sv
// Read-side sequencer for the counter RAM: sweeps an inclusive address range and streams
// {address, count}, optionally clearing each entry. CONTADORES_SKIP_ZERO_EN drops zero entries.
module contadores_reader
    import contadores_pkg::*;
#(
    parameter int unsigned bitsDirect  = BITS_DIRECT,
    parameter int unsigned sizeCounter = SIZE_COUNTER
) (
    input  logic                  clk,
    input  logic                  gen_reset_n,
    input  logic                  start,
    input  logic                  clear_en,
    input  logic [bitsDirect-1:0] first_addr,
    input  logic [bitsDirect-1:0] last_addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    contadores_if.master          bus
);

    state_e                state_q;
    logic                  clear_q;
    logic                  abort_q;

    logic [bitsDirect-1:0] idx;
    logic [bitsDirect-1:0] idx_inc;
    logic                  is_last;

    logic                  load;
    logic                  step;
    logic                  finish;
    logic                  inc;
    logic                  skip_zero;

    contadores_addr_gen #(
        .bitsDirect (bitsDirect)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (gen_reset_n),
        .load_i       (load),
        .inc_i        (inc),
        .first_addr_i (first_addr),
        .last_addr_i  (last_addr),
        .idx_o        (idx),
        .idx_inc_o    (idx_inc),
        .is_last_o    (is_last)
    );

    // step marks an entry boundary: the point where the scan either ends or moves on.
    always_comb begin
        skip_zero = 1'b0;
`ifdef CONTADORES_SKIP_ZERO_EN
        skip_zero = (state_q == StWait) && (bus.ram_count_out == '0);
`endif
        load   = (state_q == StIdle) && start;
        finish = is_last || abort_q || abort;
        step   = ((state_q == StSend) && bus.out_ready && !clear_q)
                 || (state_q == StClear)
                 || skip_zero;
        inc    = step && !finish;
    end

    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            state_q             <= StIdle;
            clear_q             <= 1'b0;
            abort_q             <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            bus.ram_adress      <= '0;
            bus.ram_count_read  <= 1'b0;
            bus.ram_count_reset <= 1'b0;
            bus.out_valid       <= 1'b0;
            bus.out_addr        <= '0;
            bus.out_count       <= {sizeCounter{1'b0}};
        end else begin
            bus.ram_count_read  <= 1'b0;
            bus.ram_count_reset <= 1'b0;
            done                <= 1'b0;

            if (abort && (state_q != StIdle) && (state_q != StDone)) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q            <= StIssue;
                        busy               <= 1'b1;
                        clear_q            <= clear_en;
                        abort_q            <= 1'b0;
                        bus.ram_adress     <= first_addr;
                        bus.ram_count_read <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    bus.out_addr  <= idx;
                    bus.out_count <= bus.ram_count_out;
                    if (!skip_zero) begin
                        bus.out_valid <= 1'b1;
                        state_q       <= StSend;
                    end
                end
                StSend: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (clear_q) begin
                            state_q             <= StClear;
                            bus.ram_adress      <= idx;
                            bus.ram_count_reset <= 1'b1;
                        end
                    end
                end
                StClear: begin
                end
                StDone: begin
                    state_q <= StIdle;
                    abort_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Entry boundary overrides the per-state next state chosen above.
            if (step) begin
                if (finish) begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state_q            <= StIssue;
                    bus.ram_adress     <= idx_inc;
                    bus.ram_count_read <= 1'b1;
                end
            end
        end
    end

endmodule
